// File: rtl/bullet_hit_pkg.sv
// Purpose: shared defaults, FSM state encoding and score ceiling for bullet_hit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bullet_hit_pkg;

    localparam int ROW_W_DEF   = 118;
    localparam int SCORE_W_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [SCORE_W_DEF-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/score_sat_acc.sv
// Purpose: running score register that adds an 8-bit value and clamps at all-ones.
// Latency: 1 cycle from add_en to updated score.
// Backpressure: none; every add_en is accepted.
module score_sat_acc
    import bullet_hit_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               add_en,
    input  logic [7:0]         add_val,
    output logic [SCORE_W-1:0] score
);

    localparam logic [SCORE_W-1:0] MAX_VAL = '1;

    logic [SCORE_W-1:0] acc_q;
    logic [SCORE_W:0]   sum;

    // One extra bit on the sum exposes the carry used for saturation.
    always_comb begin
        sum = {1'b0, acc_q} + {{(SCORE_W + 1 - 8){1'b0}}, add_val};
    end

    // Accumulate on request, pinning at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= sum[SCORE_W] ? MAX_VAL : sum[SCORE_W-1:0];
        end
    end

    assign score = acc_q;

endmodule

// File: rtl/bullet_hit.sv
// Purpose: snapshot a bullet/enemy row, scan one column per cycle for hits, report mask/count/score.
// Latency: done pulses ROW_W+2 cycles after the start-sampling edge; one scan in flight at a time.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
// Optional: define BULLET_HIT_LOOKAHEAD_EN to also flag a bullet whose right-hand neighbour holds an enemy.
module bullet_hit
    import bullet_hit_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ROW_W-1:0]   bulletRow,
    input  logic [ROW_W-1:0]   enemyRow,
    output logic               busy,
    output logic               done,
    output logic [ROW_W-1:0]   hitMask,
    output logic [7:0]         hitCount,
    output logic [SCORE_W-1:0] score
);

    localparam int               IDX_W    = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_W - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] bullet_snap;
    logic [ROW_W-1:0] enemy_snap;
    logic [ROW_W-1:0] work_mask;
    logic [7:0]       work_cnt;
    logic             hit_col;

`ifdef BULLET_HIT_LOOKAHEAD_EN
    // Enemy row shifted down one column; its top bit is zero, so the last
    // column naturally gets no lookahead term.
    logic [ROW_W-1:0] enemy_next;
    assign enemy_next = enemy_snap >> 1;

    // Same-column hit, or a bullet about to cross the enemy one column up.
    always_comb begin
        hit_col = (bullet_snap[idx] & enemy_snap[idx]) |
                  (bullet_snap[idx] & enemy_next[idx]);
    end
`else
    // Same-column hit only.
    always_comb begin
        hit_col = bullet_snap[idx] & enemy_snap[idx];
    end
`endif

    // Scan controller: snapshot on start, walk the columns, publish results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            bullet_snap <= '0;
            enemy_snap  <= '0;
            work_mask   <= '0;
            work_cnt    <= '0;
            hitMask     <= '0;
            hitCount    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bullet_snap <= bulletRow;
                        enemy_snap  <= enemyRow;
                        idx         <= '0;
                        work_mask   <= '0;
                        work_cnt    <= '0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_col) begin
                        work_mask[idx] <= 1'b1;
                        work_cnt       <= work_cnt + 8'd1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_REPORT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_REPORT: begin
                    hitMask  <= work_mask;
                    hitCount <= work_cnt;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // The score adds the completed scan's count while results are published.
    score_sat_acc #(
        .SCORE_W (SCORE_W)
    ) u_acc (
        .clk     (clk),
        .resetn  (resetn),
        .add_en  (state == ST_REPORT),
        .add_val (work_cnt),
        .score   (score)
    );

endmodule

// File: tb/tb_bullet_hit.sv
// Directed + randomized scans of bullet_hit checked against a whole-row reference model.
// Cycle k is the k-th cycle after the edge that samples start; done is expected in cycle 120.
// Shares the BULLET_HIT_LOOKAHEAD_EN switch with the design so the model tracks the build.
module tb_bullet_hit;

    localparam int W  = 118;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  bulletRow;
    logic [W-1:0]  enemyRow;
    logic          busy;
    logic          done;
    logic [W-1:0]  hitMask;
    logic [7:0]    hitCount;
    logic [SW-1:0] score;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: results of the last completed scan.
    logic [W-1:0] exp_mask;
    int           exp_cnt;
    int           exp_score;

    always #5 clk = ~clk;

    bullet_hit #(
        .ROW_W   (W),
        .SCORE_W (SW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bulletRow (bulletRow),
        .enemyRow  (enemyRow),
        .busy      (busy),
        .done      (done),
        .hitMask   (hitMask),
        .hitCount  (hitCount),
        .score     (score)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: whole-row hit rule, popcount, saturating add.
    function automatic logic [W-1:0] ref_mask(input logic [W-1:0] b, input logic [W-1:0] e);
        logic [W-1:0] m;
        m = b & e;
`ifdef BULLET_HIT_LOOKAHEAD_EN
        m = m | (b & (e >> 1));
`endif
        return m;
    endfunction

    function automatic logic [W-1:0] rand_row(input bit sparse);
        logic [127:0] r1;
        logic [127:0] r2;
        r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        r2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        return sparse ? W'(r1 & r2) : W'(r1);
    endfunction

    // Run one scan: restart_at / reset_at are cycle numbers (0 = unused).
    task automatic do_scan(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                           input bit scramble, input int restart_at, input int reset_at);
        logic [W-1:0] nm;
        int           nc;
        int           first_done;
        int           ndone;
        nm = ref_mask(b, e);
        nc = $countones(nm);
        first_done = 0;
        ndone = 0;
        bulletRow = b;
        enemyRow  = e;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            if (cyc == 60 && reset_at != 60) begin
                check({tag, " busy mid-scan"}, 128'(busy), 128'(1));
                check({tag, " hitCount held mid-scan"}, 128'(hitCount), 128'(exp_cnt));
            end
            if (reset_at != 0 && cyc == reset_at + 1) begin
                exp_mask  = '0;
                exp_cnt   = 0;
                exp_score = 0;
                check({tag, " busy after reset"}, 128'(busy), 128'(0));
                check({tag, " score after reset"}, 128'(score), 128'(0));
                check({tag, " hitCount after reset"}, 128'(hitCount), 128'(0));
                resetn = 1'b1;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = cyc;
                    exp_mask   = nm;
                    exp_cnt    = nc;
                    exp_score  = (exp_score + nc > 65535) ? 65535 : exp_score + nc;
                end
            end
            if (scramble) begin
                bulletRow = rand_row(1'b0);
                enemyRow  = rand_row(1'b0);
            end
            start = (cyc == restart_at);
            if (cyc == reset_at) resetn = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (reset_at != 0) begin
            check({tag, " done count"}, 128'(ndone), 128'(0));
        end else begin
            check({tag, " done cycle"}, 128'(first_done), 128'(W + 2));
            check({tag, " done count"}, 128'(ndone), 128'(1));
        end
        check({tag, " idle at end"}, 128'(busy), 128'(0));
        check({tag, " hitMask"}, 128'(hitMask), 128'(exp_mask));
        check({tag, " hitCount"}, 128'(hitCount), 128'(exp_cnt));
        check({tag, " score"}, 128'(score), 128'(exp_score));
    endtask

    initial begin
        logic [W-1:0] b;
        logic [W-1:0] e;
        resetn    = 1'b0;
        start     = 1'b0;
        bulletRow = '0;
        enemyRow  = '0;
        exp_mask  = '0;
        exp_cnt   = 0;
        exp_score = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset hitMask", 128'(hitMask), 128'(0));
        check("reset hitCount", 128'(hitCount), 128'(0));
        check("reset score", 128'(score), 128'(0));
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single hit in column 5.
        b = '0; b[5] = 1'b1;
        e = '0; e[5] = 1'b1;
        do_scan("col5", b, e, 1'b0, 0, 0);
        check("col5 direct mask", 128'(hitMask), 128'(1) << 5);
        check("col5 direct count", 128'(hitCount), 128'(1));
        check("col5 direct score", 128'(score), 128'(1));

        // Full bullet row against enemies at the edges and middle.
        b = '1;
        e = '0; e[0] = 1'b1; e[50] = 1'b1; e[117] = 1'b1;
        do_scan("edges", b, e, 1'b0, 0, 0);
`ifndef BULLET_HIT_LOOKAHEAD_EN
        check("edges direct count", 128'(hitCount), 128'(3));
        check("edges direct mask", 128'(hitMask), 128'(e));
`endif

        // Empty rows still run to completion.
        do_scan("empty", '0, '0, 1'b0, 0, 0);

        // Start during SCAN and during REPORT must be dropped.
        do_scan("restart10", rand_row(1'b1), rand_row(1'b1), 1'b0, 10, 0);
        do_scan("restart_report", rand_row(1'b1), rand_row(1'b1), 1'b0, 119, 0);

        // Inputs wiggling mid-scan must not leak into the result.
        do_scan("scramble", rand_row(1'b0), rand_row(1'b0), 1'b1, 0, 0);

        // Randomized scans.
        for (int i = 0; i < 4; i++) begin
            do_scan("random", rand_row(i[0]), rand_row(1'b0), 1'b0, 0, 0);
        end

        // Lookahead case: bullet one column below an enemy.
        b = '0; b[9]  = 1'b1;
        e = '0; e[10] = 1'b1;
        do_scan("lookahead", b, e, 1'b0, 0, 0);
`ifdef BULLET_HIT_LOOKAHEAD_EN
        check("lookahead direct count", 128'(hitCount), 128'(1));
`else
        check("lookahead direct count", 128'(hitCount), 128'(0));
`endif

        // Reset in the middle of a scan aborts it.
        do_scan("midreset", '1, '1, 1'b0, 0, 60);

        // Saturation: preload the accumulator just below the ceiling.
        force dut.u_acc.acc_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.u_acc.acc_q;
        exp_score = 16'hFFFE;
        check("preload score", 128'(score), 128'(16'hFFFE));
        b = '0; b[1] = 1'b1; b[2] = 1'b1; b[3] = 1'b1;
        do_scan("sat3", b, b, 1'b0, 0, 0);
        check("sat3 direct score", 128'(score), 128'(16'hFFFF));
        do_scan("sat_full", '1, '1, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
